// File: rtl/id_rn_pkg.sv
// Shared definitions for the ID->RN elastic pipeline register.
// Holds the lane width calculation, lane field offsets and occupancy states.
package id_rn_pkg;

    // Occupancy states; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    // Lane layout, MSB to LSB: {aluop, regw, src1, src2, rdst, imm}.
    function automatic int lane_w(input int aluop_w,
                                  input int reg_w,
                                  input int imm_w);
        return aluop_w + 1 + 3 * reg_w + imm_w;
    endfunction

    function automatic int off_imm();
        return 0;
    endfunction

    function automatic int off_rdst(input int imm_w);
        return imm_w;
    endfunction

    function automatic int off_src2(input int reg_w,
                                    input int imm_w);
        return imm_w + reg_w;
    endfunction

    function automatic int off_src1(input int reg_w,
                                    input int imm_w);
        return imm_w + 2 * reg_w;
    endfunction

    function automatic int off_regw(input int reg_w,
                                    input int imm_w);
        return imm_w + 3 * reg_w;
    endfunction

    function automatic int off_aluop(input int reg_w,
                                     input int imm_w);
        return imm_w + 3 * reg_w + 1;
    endfunction

endpackage

// File: rtl/id_rn_group_slot.sv
// Single fetch-group register {lane_valid, bundle, pc, gtag}.
// Ports: clk, rst, clr (drops lane valids only), load, d_* inputs, q_* outputs.
module id_rn_group_slot #(
    parameter int LANES  = 4,
    parameter int BW     = 228,
    parameter int PC_W   = 32,
    parameter int GTAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [LANES-1:0]  d_lane_valid,
    input  logic [BW-1:0]     d_bundle,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [GTAG_W-1:0] d_gtag,
    output logic [LANES-1:0]  q_lane_valid,
    output logic [BW-1:0]     q_bundle,
    output logic [PC_W-1:0]   q_pc,
    output logic [GTAG_W-1:0] q_gtag
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_lane_valid <= '0;
            q_bundle     <= '0;
            q_pc         <= '0;
            q_gtag       <= '0;
        end else if (clr) begin
            // Payload is kept; only the lane valids are dropped.
            q_lane_valid <= '0;
        end else if (load) begin
            q_lane_valid <= d_lane_valid;
            q_bundle     <= d_bundle;
            q_pc         <= d_pc;
            q_gtag       <= d_gtag;
        end
    end

endmodule

// File: rtl/id_rn_elastic_reg.sv
// N-lane decode->rename register with valid/ready handshake and skid slot.
// Ports: clk, rst, flush, in_* (from ID), out_* (to RN), occupancy.
module id_rn_elastic_reg
    import id_rn_pkg::*;
#(
    parameter  int LANES   = 4,
    parameter  int ALUOP_W = 9,
    parameter  int REG_W   = 5,
    parameter  int IMM_W   = 32,
    parameter  int PC_W    = 32,
    parameter  int GTAG_W  = 4,
    localparam int LANE_W  = lane_w(ALUOP_W, REG_W, IMM_W),
    localparam int BW      = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANES-1:0]  in_lane_valid,
    input  logic [BW-1:0]     in_bundle,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANES-1:0]  out_lane_valid,
    output logic [BW-1:0]     out_bundle,
    output logic [PC_W-1:0]   out_pc,
    output logic [GTAG_W-1:0] out_gtag,
    output logic [1:0]        occupancy
);

    occ_state_t        state;
    occ_state_t        state_n;
    logic [GTAG_W-1:0] tag;

    logic accept;
    logic store;
    logic consume;
    logic main_load;
    logic main_from_skid;
    logic skid_load;

    logic [LANES-1:0]  main_lv;
    logic [LANES-1:0]  skid_lv;
    logic [BW-1:0]     skid_bundle;
    logic [PC_W-1:0]   skid_pc;
    logic [GTAG_W-1:0] skid_gtag;

    logic [LANES-1:0]  main_d_lv;
    logic [BW-1:0]     main_d_bundle;
    logic [PC_W-1:0]   main_d_pc;
    logic [GTAG_W-1:0] main_d_gtag;

    // Ready depends only on state, never on out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;

    assign accept  = in_valid & in_ready;
    // All-invalid groups are swallowed here.
    assign store   = accept & (|in_lane_valid);
    assign consume = out_valid & out_ready;

    always_comb begin
        state_n        = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (store) begin
                        main_load = 1'b1;
                        state_n   = ONE;
                    end
                end
                ONE: begin
                    if (store && consume) begin
                        main_load = 1'b1;
                    end else if (store) begin
                        skid_load = 1'b1;
                        state_n   = FULL;
                    end else if (consume) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_n        = ONE;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            tag   <= '0;
        end else begin
            state <= state_n;
            // Flush does not rewind the tag; a discarded group takes none.
            if (store && !flush) begin
                tag <= tag + GTAG_W'(1);
            end
        end
    end

    assign main_d_lv     = main_from_skid ? skid_lv     : in_lane_valid;
    assign main_d_bundle = main_from_skid ? skid_bundle : in_bundle;
    assign main_d_pc     = main_from_skid ? skid_pc     : in_pc;
    assign main_d_gtag   = main_from_skid ? skid_gtag   : tag;

    id_rn_group_slot #(
        .LANES  (LANES),
        .BW     (BW),
        .PC_W   (PC_W),
        .GTAG_W (GTAG_W)
    ) u_main (
        .clk          (clk),
        .rst          (rst),
        .clr          (flush),
        .load         (main_load),
        .d_lane_valid (main_d_lv),
        .d_bundle     (main_d_bundle),
        .d_pc         (main_d_pc),
        .d_gtag       (main_d_gtag),
        .q_lane_valid (main_lv),
        .q_bundle     (out_bundle),
        .q_pc         (out_pc),
        .q_gtag       (out_gtag)
    );

    id_rn_group_slot #(
        .LANES  (LANES),
        .BW     (BW),
        .PC_W   (PC_W),
        .GTAG_W (GTAG_W)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .clr          (flush),
        .load         (skid_load),
        .d_lane_valid (in_lane_valid),
        .d_bundle     (in_bundle),
        .d_pc         (in_pc),
        .d_gtag       (tag),
        .q_lane_valid (skid_lv),
        .q_bundle     (skid_bundle),
        .q_pc         (skid_pc),
        .q_gtag       (skid_gtag)
    );

    assign out_lane_valid = out_valid ? main_lv : '0;

endmodule

// File: tb/tb_id_rn_elastic_reg.sv
// Scoreboard bench for id_rn_elastic_reg with default parameters.
// Stimulus pushes expected groups; a negedge monitor pops and compares.
module tb_id_rn_elastic_reg;

    localparam int LN = 4;
    localparam int LW = 57;
    localparam int BW = LN * LW;

    typedef struct packed {
        logic [LN-1:0] lv;
        logic [31:0]   pc;
        logic [BW-1:0] b;
        logic [3:0]    tag;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [LN-1:0] in_lane_valid;
    logic [BW-1:0] in_bundle;
    logic [31:0]   in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [LN-1:0] out_lane_valid;
    logic [BW-1:0] out_bundle;
    logic [31:0]   out_pc;
    logic [3:0]    out_gtag;
    logic [1:0]    occupancy;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         lat_on = 1'b0;
    logic [3:0] mtag  = 4'd0;
    exp_t       sb[$];
    logic [3:0] got_tag[$];

    id_rn_elastic_reg dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_bundle      (in_bundle),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_bundle     (out_bundle),
        .out_pc         (out_pc),
        .out_gtag       (out_gtag),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n,
                       input logic [255:0] got,
                       input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int k);
        logic [255:0] t;
        logic [31:0]  w;
        w = 32'(k) * 32'h9E37_79B1 + 32'h1234_5678;
        t = {8{w}};
        return t[BW-1:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (!out_valid) chk("idle_lane_valid", out_lane_valid, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_group got=tag%0h want=none",
                             out_gtag);
                end else begin
                    e = sb.pop_front();
                    chk("lane_valid", out_lane_valid, e.lv);
                    chk("pc", out_pc, e.pc);
                    chk("bundle", out_bundle, e.b);
                    chk("gtag", out_gtag, e.tag);
                    if (lat_on) chk("latency", cyc, e.acc + 1);
                    got_tag.push_back(out_gtag);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [LN-1:0] lv,
                        input logic [31:0] pc,
                        input int k);
        int   n;
        bit   ok;
        exp_t e;
        in_valid      = 1'b1;
        in_lane_valid = lv;
        in_pc         = pc;
        in_bundle     = mk(k);
        n  = 0;
        ok = 1'b0;
        e  = '0;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok    = in_ready;
            e.acc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=notready want=accept");
        end else if (lv != '0) begin
            e.lv  = lv;
            e.pc  = pc;
            e.b   = mk(k);
            e.tag = mtag;
            mtag  = mtag + 4'd1;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string n);
        chk({n, "_out_valid"}, out_valid, 0);
        chk({n, "_lane_valid"}, out_lane_valid, 0);
        chk({n, "_bundle"}, out_bundle, 0);
        chk({n, "_pc"}, out_pc, 0);
        chk({n, "_gtag"}, out_gtag, 0);
        chk({n, "_occupancy"}, occupancy, 0);
        chk({n, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_lane_valid = '0;
        in_bundle     = '0;
        in_pc         = '0;
        out_ready     = 1'b0;

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;

        // 2: streaming, one group per cycle
        out_ready = 1'b1;
        lat_on    = 1'b1;
        got_tag.delete();
        for (int i = 0; i < 10; i++) begin
            send(4'b1111, 32'h0040_0000 + 32'(16 * i), i);
            if (i == 5) chk("stream_occupancy", occupancy, 1);
        end
        drain();
        lat_on = 1'b0;
        chk("stream_count", got_tag.size(), 10);
        if (got_tag.size() == 10)
            for (int i = 0; i < 10; i++)
                chk("stream_tag", got_tag[i], i);

        // 3: backpressure fills main and skid
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        got_tag.delete();
        send(4'b1111, 32'h0040_1000, 100);
        send(4'b0011, 32'h0040_1010, 101);
        @(negedge clk);
        chk("full_occupancy", occupancy, 2);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid      = 1'b1;
        in_lane_valid = 4'b0101;
        in_pc         = 32'h0040_1020;
        in_bundle     = mk(102);
        repeat (2) begin
            @(negedge clk);
            chk("blocked_ready", in_ready, 0);
            chk("blocked_occ", occupancy, 2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(4'b0101, 32'h0040_1020, 102);
        drain();
        if (got_tag.size() == 3) begin
            chk("bp_tag0", got_tag[0], 10);
            chk("bp_tag2", got_tag[2], 12);
        end else begin
            chk("bp_count", got_tag.size(), 3);
        end

        // 4: squashed group between two valid ones
        got_tag.delete();
        send(4'b1000, 32'h0040_2000, 200);
        send(4'b0000, 32'h0040_2010, 201);
        send(4'b0001, 32'h0040_2020, 202);
        drain();
        if (got_tag.size() == 2) begin
            chk("squash_tag_a", got_tag[0], 13);
            chk("squash_tag_b", got_tag[1], 14);
        end else begin
            chk("squash_count", got_tag.size(), 2);
        end

        // 5: flush while full with an input beat
        out_ready = 1'b0;
        send(4'b1111, 32'h0040_3000, 300);
        send(4'b1111, 32'h0040_3010, 301);
        flush         = 1'b1;
        in_valid      = 1'b1;
        in_lane_valid = 4'b1111;
        in_pc         = 32'h0040_3020;
        in_bundle     = mk(302);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_in_ready", in_ready, 1);
        sb.delete();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        got_tag.delete();
        send(4'b0110, 32'h0040_3030, 303);
        drain();
        if (got_tag.size() == 1) chk("flush_next_tag", got_tag[0], 1);
        else chk("flush_next_count", got_tag.size(), 1);

        // 6: reset while full, then tag wrap
        out_ready = 1'b0;
        send(4'b1111, 32'h0040_4000, 400);
        send(4'b1111, 32'h0040_4010, 401);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        sb.delete();
        mtag = 4'd0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        got_tag.delete();
        for (int i = 0; i < 17; i++)
            send(4'b1111, 32'h0040_5000 + 32'(16 * i), 500 + i);
        drain();
        if (got_tag.size() == 17) begin
            chk("wrap_tag15", got_tag[15], 15);
            chk("wrap_tag16", got_tag[16], 0);
        end else begin
            chk("wrap_count", got_tag.size(), 17);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
